// File: rtl/sort_scheduler_pkg.sv
// Shared types for the sort scheduler: FSM state encoding and
// a helper that sizes channel-index fields (at least one bit wide).
package sort_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DRAIN,
        WAIT_OUT
    } state_t;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: returns the first requesting index
// at or after ptr (with wrap). Ports: req, ptr -> grant_idx, grant_vld.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant_idx,
    output logic         grant_vld
);

    logic [W:0]   sum;
    logic [W-1:0] k;

    // Scan from the far end back toward ptr so the last hit is the
    // closest one to ptr, which avoids needing an early loop exit.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        sum       = '0;
        k         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (W + 1)'(i);
            if (sum >= (W + 1)'(N)) begin
                sum = sum - (W + 1)'(N);
            end
            k = sum[W-1:0];
            if (req[k]) begin
                grant_idx = k;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sort_scheduler.sv
// Shares one sorting engine between N_CH Avalon-ST channels, whole packet
// at a time, with round-robin grant, truncation and orphan-word draining.
// Ports: ch_snk_* (channel inputs), ch_src_* (sorted outputs to channels),
// eng_snk_*/eng_src_* (engine side), owner_o, busy_o, err_oversize_o,
// err_orphan_o. Clock clk_i, async active-high reset arst_i.
module sort_scheduler
    import sort_scheduler_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DWIDTH      = 64,
    parameter int MAX_PKT_LEN = 128,
    localparam int CH_IDX_W   = ch_idx_w(N_CH)
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic [N_CH*DWIDTH-1:0]   ch_snk_data_i,
    input  logic [N_CH-1:0]          ch_snk_startofpacket_i,
    input  logic [N_CH-1:0]          ch_snk_endofpacket_i,
    input  logic [N_CH-1:0]          ch_snk_valid_i,
    output logic [N_CH-1:0]          ch_snk_ready_o,
    output logic [N_CH*DWIDTH-1:0]   ch_src_data_o,
    output logic [N_CH-1:0]          ch_src_startofpacket_o,
    output logic [N_CH-1:0]          ch_src_endofpacket_o,
    output logic [N_CH-1:0]          ch_src_valid_o,
    input  logic [N_CH-1:0]          ch_src_ready_i,
    output logic [DWIDTH-1:0]        eng_snk_data_o,
    output logic                     eng_snk_startofpacket_o,
    output logic                     eng_snk_endofpacket_o,
    output logic                     eng_snk_valid_o,
    input  logic                     eng_snk_ready_i,
    input  logic [DWIDTH-1:0]        eng_src_data_i,
    input  logic                     eng_src_startofpacket_i,
    input  logic                     eng_src_endofpacket_i,
    input  logic                     eng_src_valid_i,
    output logic                     eng_src_ready_o,
    output logic [CH_IDX_W-1:0]      owner_o,
    output logic                     busy_o,
    output logic                     err_oversize_o,
    output logic                     err_orphan_o
);

    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT_LEN - 1);

    state_t              state;
    logic [CH_IDX_W-1:0] owner;
    logic [CH_IDX_W-1:0] rr_ptr;
    logic [CH_IDX_W-1:0] next_ptr;
    logic [CNT_W-1:0]    word_cnt;
    logic                err_ov_q;
    logic                err_or_q;

    logic [N_CH-1:0]     req;
    logic [CH_IDX_W-1:0] gnt_idx;
    logic                gnt_vld;

    logic [DWIDTH-1:0]   own_data;
    logic                own_vld;
    logic                own_sop;
    logic                own_eop;
    logic                last_slot;
    logic                snk_xfer;
    logic                src_xfer;

    assign req = ch_snk_valid_i & ch_snk_startofpacket_i;

    rr_arbiter #(
        .N (N_CH),
        .W (CH_IDX_W)
    ) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant_idx (gnt_idx),
        .grant_vld (gnt_vld)
    );

    assign own_data  = ch_snk_data_i[int'(owner)*DWIDTH +: DWIDTH];
    assign own_vld   = ch_snk_valid_i[owner];
    assign own_sop   = ch_snk_startofpacket_i[owner];
    assign own_eop   = ch_snk_endofpacket_i[owner];
    assign last_slot = (word_cnt == LAST_CNT);
    assign snk_xfer  = own_vld & eng_snk_ready_i;
    assign src_xfer  = eng_src_valid_i & eng_src_ready_o;
    assign next_ptr  = (int'(owner) == N_CH - 1) ? '0
                                                  : owner + CH_IDX_W'(1);

    assign ch_src_data_o  = {N_CH{eng_src_data_i}};
    assign eng_snk_data_o = own_data;
    assign owner_o        = owner;
    assign busy_o         = (state != IDLE);
    assign err_oversize_o = err_ov_q;
    assign err_orphan_o   = err_or_q;

    // Handshake outputs are forced low while reset is held so that
    // nothing is accepted or presented until the FSM is released.
    always_comb begin
        ch_snk_ready_o          = '0;
        eng_snk_valid_o         = 1'b0;
        eng_snk_startofpacket_o = 1'b0;
        eng_snk_endofpacket_o   = 1'b0;
        ch_src_valid_o          = '0;
        ch_src_startofpacket_o  = '0;
        ch_src_endofpacket_o    = '0;
        eng_src_ready_o         = 1'b0;
        if (!arst_i) begin
            unique case (state)
                IDLE: begin
                    // sop words wait for a grant; anything else is drained
                    ch_snk_ready_o = ~ch_snk_startofpacket_i;
                end
                FWD: begin
                    eng_snk_valid_o         = own_vld;
                    eng_snk_startofpacket_o = own_sop & (word_cnt == '0);
                    eng_snk_endofpacket_o   = own_eop | last_slot;
                    ch_snk_ready_o[owner]   = eng_snk_ready_i;
                end
                DRAIN: begin
                    ch_snk_ready_o[owner] = 1'b1;
                end
                WAIT_OUT: begin
                    ch_src_valid_o[owner]         = eng_src_valid_i;
                    ch_src_startofpacket_o[owner] = eng_src_startofpacket_i;
                    ch_src_endofpacket_o[owner]   = eng_src_endofpacket_i;
                    eng_src_ready_o               = ch_src_ready_i[owner];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            word_cnt <= '0;
            err_ov_q <= 1'b0;
            err_or_q <= 1'b0;
        end else begin
            err_ov_q <= 1'b0;
            err_or_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    err_or_q <= |(ch_snk_valid_i & ~ch_snk_startofpacket_i);
                    word_cnt <= '0;
                    if (gnt_vld) begin
                        owner <= gnt_idx;
                        state <= FWD;
                    end
                end
                FWD: begin
                    if (snk_xfer) begin
                        word_cnt <= word_cnt + CNT_W'(1);
                        if (own_eop) begin
                            state <= WAIT_OUT;
                        end else if (last_slot) begin
                            err_ov_q <= 1'b1;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (own_vld && own_eop) begin
                        state <= WAIT_OUT;
                    end
                end
                WAIT_OUT: begin
                    if (src_xfer && eng_src_endofpacket_i) begin
                        state    <= IDLE;
                        rr_ptr   <= next_ptr;
                        word_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
